// File: rtl/series_result_buffer.sv
// Captures one result per series-engine busy run (value sampled on the busy fall, plus its busy-cycle count) into a small FIFO.
// Define RESULT_DROP_OLDEST_EN so that a push into a full FIFO overwrites the oldest entry; otherwise the new result is discarded.
module series_result_buffer #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         eng_busy,
    input  logic [W-1:0] eng_result,
    input  logic         out_ack,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic [7:0]   out_cycles,
    output logic [4:0]   level,
    output logic         full,
    output logic         empty,
    output logic         dropped
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int EW = W + 8;

`ifdef RESULT_DROP_OLDEST_EN
    localparam logic DROP_OLDEST = 1'b1;
`else
    localparam logic DROP_OLDEST = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_CAP
    } state_t;

    state_t                   state_q, state_d;
    logic [7:0]               cnt_q, cnt_d;
    logic [W-1:0]             result_q, result_d;
    logic [DEPTH-1:0][EW-1:0] mem_q, mem_d;
    logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [4:0]               level_q, level_d;
    logic                     dropped_q, dropped_d;

    logic          full_w;
    logic          empty_w;
    logic          push_req;
    logic          pop_ok;
    logic          overflow;
    logic          do_write;
    logic          adv_rd;
    logic [EW-1:0] head;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (eng_busy) begin
                    state_d = S_RUN;
                    cnt_d   = 8'd1;
                end
            end
            S_RUN: begin
                if (eng_busy) begin
                    if (cnt_q != 8'hFF) begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else begin
                    state_d  = S_CAP;
                    result_d = eng_result;
                end
            end
            S_CAP: begin
                // The push cycle can already be the first busy cycle of the next run.
                if (eng_busy) begin
                    state_d = S_RUN;
                    cnt_d   = 8'd1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign full_w   = (level_q == 5'(DEPTH));
    assign empty_w  = (level_q == 5'd0);
    assign push_req = (state_q == S_CAP);
    assign pop_ok   = out_ack && !empty_w;
    assign overflow = push_req && full_w && !pop_ok;
    assign do_write = push_req && (!overflow || DROP_OLDEST);
    assign adv_rd   = pop_ok || (overflow && DROP_OLDEST);

    always_comb begin
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        dropped_d = dropped_q | overflow;
        // When full, wr_ptr equals rd_ptr, so overwrite-oldest reuses the head slot.
        if (do_write) begin
            mem_d[wr_ptr_q] = {result_q, cnt_q};
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (adv_rd) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        level_d = level_q + 5'(do_write) - 5'(adv_rd);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 8'd0;
            result_q  <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= 5'd0;
            dropped_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            result_q  <= result_d;
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            dropped_q <= dropped_d;
        end
    end

    // Storage is not reset, so the head is gated to zero while the FIFO is empty.
    assign head       = empty_w ? '0 : mem_q[rd_ptr_q];
    assign out_valid  = !empty_w;
    assign out_data   = head[EW-1:8];
    assign out_cycles = head[7:0];
    assign level      = level_q;
    assign full       = full_w;
    assign empty      = empty_w;
    assign dropped    = dropped_q;

endmodule

// File: tb/tb_series_result_buffer.sv
// Self-checking bench for series_result_buffer: directed scenarios plus random traffic checked against a queue-based model.
module tb_series_result_buffer;

    localparam int DEPTH = 4;
    localparam int W     = 16;

    logic         clock = 1'b0;
    logic         reset;
    logic         eng_busy;
    logic [W-1:0] eng_result;
    logic         out_ack;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic [7:0]   out_cycles;
    logic [4:0]   level;
    logic         full;
    logic         empty;
    logic         dropped;

    int errors = 0;
    int checks = 0;

    // Reference model: a queue of {result, cycles} plus a run tracker.
    logic [W+7:0] mq[$];
    bit           m_run;
    int           m_len;
    bit           m_pend;
    logic [W+7:0] m_pend_e;
    bit           m_drop;

    series_result_buffer #(.DEPTH(DEPTH), .W(W)) dut (
        .clock      (clock),
        .reset      (reset),
        .eng_busy   (eng_busy),
        .eng_result (eng_result),
        .out_ack    (out_ack),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_cycles (out_cycles),
        .level      (level),
        .full       (full),
        .empty      (empty),
        .dropped    (dropped)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic modelStep(input logic rst, input logic busy, input logic [W-1:0] res, input logic ack);
        bit           next_pend;
        logic [W+7:0] next_e;
        if (rst) begin
            mq.delete();
            m_run  = 0;
            m_len  = 0;
            m_pend = 0;
            m_drop = 0;
            return;
        end
        if (ack && mq.size() > 0) begin
            void'(mq.pop_front());
        end
        if (m_pend) begin
            if (mq.size() < DEPTH) begin
                mq.push_back(m_pend_e);
            end else begin
                m_drop = 1;
`ifdef RESULT_DROP_OLDEST_EN
                void'(mq.pop_front());
                mq.push_back(m_pend_e);
`endif
            end
        end
        next_pend = 0;
        next_e    = '0;
        if (m_run) begin
            if (busy) begin
                m_len = (m_len < 255) ? m_len + 1 : 255;
            end else begin
                next_pend = 1;
                next_e    = {res, 8'(m_len)};
                m_run     = 0;
            end
        end else if (busy) begin
            m_run = 1;
            m_len = 1;
        end
        m_pend   = next_pend;
        m_pend_e = next_e;
    endtask

    task automatic checkAll();
        logic [W+7:0] exp_head;
        exp_head = (mq.size() > 0) ? mq[0] : '0;
        checkOutput("out_valid", 32'(out_valid), 32'(mq.size() > 0));
        checkOutput("empty", 32'(empty), 32'(mq.size() == 0));
        checkOutput("full", 32'(full), 32'(mq.size() == DEPTH));
        checkOutput("level", 32'(level), 32'(mq.size()));
        checkOutput("dropped", 32'(dropped), 32'(m_drop));
        checkOutput("out_data", 32'(out_data), 32'(exp_head[W+7:8]));
        checkOutput("out_cycles", 32'(out_cycles), 32'(exp_head[7:0]));
    endtask

    task automatic applyStimulus(input logic rst, input logic busy, input logic [W-1:0] res, input logic ack);
        reset      = rst;
        eng_busy   = busy;
        eng_result = res;
        out_ack    = ack;
        @(posedge clock);
        modelStep(rst, busy, res, ack);
        #1;
        checkAll();
    endtask

    task automatic doRun(input int len, input logic [W-1:0] res, input logic ack_on_push);
        for (int i = 0; i < len; i++) begin
            applyStimulus(1'b0, 1'b1, W'($urandom), 1'b0);
        end
        applyStimulus(1'b0, 1'b0, res, 1'b0);
        applyStimulus(1'b0, 1'b0, W'($urandom), ack_on_push);
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 1'b0, '0, 1'b0);
        checkOutput("rst_level", 32'(level), 32'd0);
        checkOutput("rst_empty", 32'(empty), 32'd1);
        checkOutput("rst_data", 32'(out_data), 32'd0);
    endtask

    initial begin
        int exp_c[4];
        int exp_d[4];
        logic rb;

        reset      = 1'b1;
        eng_busy   = 1'b0;
        eng_result = '0;
        out_ack    = 1'b0;

        // Single 16-cycle run, result visible two cycles after the fall.
        doReset();
        for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b1, 16'hBEEF, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h1234, 1'b0);
        checkOutput("a_not_early", 32'(out_valid), 32'd0);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
        checkOutput("a_valid", 32'(out_valid), 32'd1);
        checkOutput("a_data", 32'(out_data), 32'h1234);
        checkOutput("a_cycles", 32'(out_cycles), 32'd16);
        checkOutput("a_level", 32'(level), 32'd1);

        // Fill with 1..4, then drain in order.
        doReset();
        for (int i = 1; i <= 4; i++) doRun(i, W'(i), 1'b0);
        checkOutput("b_full", 32'(full), 32'd1);
        checkOutput("b_level", 32'(level), 32'd4);
        for (int i = 1; i <= 4; i++) begin
            checkOutput("b_order", 32'(out_data), 32'(i));
            applyStimulus(1'b0, 1'b0, '0, 1'b1);
        end
        checkOutput("b_empty", 32'(empty), 32'd1);

        // Fifth push into a full FIFO without ack.
        doReset();
        for (int i = 1; i <= 4; i++) doRun(2, W'(i), 1'b0);
        doRun(2, 16'd5, 1'b0);
        checkOutput("c_dropped", 32'(dropped), 32'd1);
        checkOutput("c_level", 32'(level), 32'd4);
`ifdef RESULT_DROP_OLDEST_EN
        exp_c = '{2, 3, 4, 5};
`else
        exp_c = '{1, 2, 3, 4};
`endif
        for (int i = 0; i < 4; i++) begin
            checkOutput("c_order", 32'(out_data), 32'(exp_c[i]));
            applyStimulus(1'b0, 1'b0, '0, 1'b1);
        end
        checkOutput("c_sticky", 32'(dropped), 32'd1);

        // Push into a full FIFO with a same-cycle ack.
        doReset();
        for (int i = 1; i <= 4; i++) doRun(1, W'(i), 1'b0);
        doRun(3, 16'd5, 1'b1);
        checkOutput("d_level", 32'(level), 32'd4);
        checkOutput("d_dropped", 32'(dropped), 32'd0);
        exp_d = '{2, 3, 4, 5};
        for (int i = 0; i < 4; i++) begin
            checkOutput("d_order", 32'(out_data), 32'(exp_d[i]));
            applyStimulus(1'b0, 1'b0, '0, 1'b1);
        end

        // Reset during a run and during the capture cycle discards the result.
        doReset();
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 16'h0055, 1'b0);
        applyStimulus(1'b1, 1'b1, 16'h0055, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0066, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
        checkOutput("e_level", 32'(level), 32'd0);
        checkOutput("e_dropped", 32'(dropped), 32'd0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 16'h0077, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0077, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h0000, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
        checkOutput("e_cap_level", 32'(level), 32'd0);

        // Saturating count, back-to-back runs and a one-cycle pulse.
        doReset();
        doRun(300, 16'hAAAA, 1'b0);
        checkOutput("f_sat", 32'(out_cycles), 32'd255);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 16'h0000, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0011, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 16'h0000, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0022, 1'b0);
        applyStimulus(1'b0, 1'b0, 16'h0000, 1'b0);
        checkOutput("f_b2b_level", 32'(level), 32'd2);
        checkOutput("f_b2b_first", 32'(out_cycles), 32'd3);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        checkOutput("f_b2b_second", 32'(out_cycles), 32'd5);
        checkOutput("f_b2b_data", 32'(out_data), 32'h0022);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        doRun(1, 16'h0033, 1'b0);
        checkOutput("f_pulse", 32'(out_cycles), 32'd1);

        // Random traffic against the model.
        doReset();
        rb = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) rb = ~rb;
            applyStimulus(($urandom_range(0, 299) == 0), rb, W'($urandom),
                          ($urandom_range(0, 9) < 3));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/series_result_buffer.md
SERIES_RESULT_BUFFER -- requirements
Module: series_result_buffer

Interface
REQ-001 The block SHALL use one clock, named clock; reset is synchronous and active-high, named reset.
REQ-002 Parameter: DEPTH, default 4, FIFO entries (power of two, 2..16).
REQ-003 Parameter: W, default 16, result word width.
REQ-004 Ports, in order:
- clock  in  1  system clock, rising edge
- reset  in  1  sync active-high reset
- eng_busy  in  1  series engine busy
- eng_result  in  W  engine accumulator value
- out_ack  in  1  consumer accepts head entry
- out_valid  out  1  FIFO non-empty
- out_data  out  W  head entry
- out_cycles  out  8  busy-cycle count of head entry
- level  out  5  occupancy, 0..DEPTH
- full  out  1  level==DEPTH
- empty  out  1  level==0
- dropped  out  1  sticky: a completed result was lost

Function
REQ-005 Capture FSM states SHALL be S_IDLE, S_RUN, S_CAP.
- S_IDLE: eng_busy=1 -> S_RUN; busy counter cleared to 1.
- S_RUN: eng_busy=1 -> stay, busy counter +1, saturating at 255.
- S_RUN: eng_busy=0 -> S_CAP; eng_result sampled that cycle.
- S_CAP: push {sampled result, busy count} -> S_IDLE, or -> S_RUN if eng_busy=1 that cycle, with the counter restarted at 1.
REQ-006 A result SHALL be visible on out_valid/out_data two cycles after the first eng_busy=0 cycle, when the FIFO was empty.
REQ-007 out_valid SHALL equal !empty.
REQ-008 out_data and out_cycles SHALL always reflect the head entry.
REQ-009 Pop SHALL occur on a rising clock edge with out_valid=1 and out_ack=1.
REQ-010 out_ack with out_valid=0 SHALL be ignored.
REQ-011 Push and pop in the same cycle SHALL leave level unchanged and both SHALL take effect, including when full.
REQ-012 Push when full without a same-cycle pop SHALL follow REQ-019.
REQ-013 Read and write pointers SHALL wrap modulo DEPTH.
REQ-014 level SHALL be exact at every wrap.
REQ-015 An eng_busy pulse of exactly one cycle SHALL produce an entry with out_cycles=1.

Reset
REQ-016 While reset=1 at a clock edge:
- FSM -> S_IDLE
- pointers, level and busy counter -> 0
- dropped -> 0
- all outputs: out_valid=0, empty=1, full=0, level=0, out_data=0, out_cycles=0
REQ-017 Reset asserted mid-run (S_RUN or S_CAP) SHALL discard the in-flight result without pushing it and without setting dropped.
REQ-018 dropped SHALL clear only on reset.

Configuration
REQ-019 Macro RESULT_DROP_OLDEST_EN SHALL select the full-FIFO push policy.
- Defined: a push into a full FIFO overwrites the oldest entry (head advances), level stays DEPTH, dropped sets.
- Undefined: a push into a full FIFO discards the new result, FIFO is unchanged, dropped sets.

Verification
REQ-020 Scenario: reset; eng_busy high 16 cycles, eng_result=16'h1234 on its fall -> out_valid=1 two cycles after the fall, out_data=16'h1234, out_cycles=16, level=1.
REQ-021 Scenario: 4 runs with results 1,2,3,4 and out_ack=0 -> full=1, level=4; ack 4 times -> data 1,2,3,4 in order, then empty=1.
REQ-022 Scenario: full FIFO holding 1..4, fifth run with result 5, no ack -> undefined macro: head=1, dropped=1; defined: head=2, tail=5, dropped=1.
REQ-023 Scenario: full FIFO, out_ack=1 in the push cycle -> level stays 4, dropped=0, new tail present.
REQ-024 Scenario: reset pulsed while eng_busy=1 -> level=0, dropped=0, no entry appears after the later busy fall.
REQ-025 Scenario: 300-cycle busy run -> out_cycles=255; back-to-back runs with one idle cycle both captured.
